// File: rtl/miriscv_decode_queue_if.sv
`default_nettype none
// ------------------------------------------------------------------
// miriscv_decode_queue_if: fetch/execute handshake bundle. Rev 1.0
// ------------------------------------------------------------------
interface miriscv_decode_queue_if #(
    parameter int ILL_CNT_W = 16
);
    logic                 flush_i;
    logic                 instr_valid_i;
    logic [31:0]          instr_i;
    logic [31:0]          instr_pc_i;
    logic                 instr_ready_o;
    logic                 dec_valid_o;
    logic                 dec_ready_i;
    logic [31:0]          dec_instr_o;
    logic [31:0]          dec_pc_o;
    logic [1:0]           ex_op_a_sel_o;
    logic [2:0]           ex_op_b_sel_o;
    logic [5:0]           alu_op_o;
    logic                 mdu_req_o;
    logic [2:0]           mdu_op_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [2:0]           mem_size_o;
    logic                 gpr_we_a_o;
    logic [1:0]           wb_src_sel_o;
    logic                 branch_o;
    logic                 jal_o;
    logic                 jalr_o;
    logic                 illegal_instr_o;
    logic [ILL_CNT_W-1:0] ill_cnt_o;

    modport slave (
        input  flush_i, instr_valid_i, instr_i, instr_pc_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, dec_instr_o, dec_pc_o,
               ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mdu_req_o, mdu_op_o,
               mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o,
               branch_o, jal_o, jalr_o, illegal_instr_o, ill_cnt_o
    );

    modport master (
        output flush_i, instr_valid_i, instr_i, instr_pc_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, dec_instr_o, dec_pc_o,
               ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mdu_req_o, mdu_op_o,
               mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o,
               branch_o, jal_o, jalr_o, illegal_instr_o, ill_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/miriscv_decode_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// miriscv_decode_queue: FIFO-buffered RV32I(+M) decode stage. Rev 1.0
// ------------------------------------------------------------------
module miriscv_decode_queue #(
    parameter int DEPTH     = 4,
    parameter int ENABLE_M  = 1,
    parameter int ILL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    miriscv_decode_queue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] OP_A_RS1     = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC = 2'd1;
    localparam logic [1:0] OP_A_ZERO    = 2'd2;
    localparam logic [2:0] OP_B_RS2     = 3'd0;
    localparam logic [2:0] OP_B_IMM_I   = 3'd1;
    localparam logic [2:0] OP_B_IMM_U   = 3'd2;
    localparam logic [2:0] OP_B_IMM_S   = 3'd3;
    localparam logic [2:0] OP_B_INCR    = 3'd4;

    localparam logic [5:0] ALU_ADD  = 6'b011000;
    localparam logic [5:0] ALU_SUB  = 6'b011001;
    localparam logic [5:0] ALU_XOR  = 6'b101111;
    localparam logic [5:0] ALU_OR   = 6'b101110;
    localparam logic [5:0] ALU_AND  = 6'b010101;
    localparam logic [5:0] ALU_SRA  = 6'b100100;
    localparam logic [5:0] ALU_SRL  = 6'b100101;
    localparam logic [5:0] ALU_SLL  = 6'b100111;
    localparam logic [5:0] ALU_LTS  = 6'b000000;
    localparam logic [5:0] ALU_LTU  = 6'b000001;
    localparam logic [5:0] ALU_SLTS = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_GES  = 6'b001010;
    localparam logic [5:0] ALU_GEU  = 6'b001011;
    localparam logic [5:0] ALU_EQ   = 6'b001100;
    localparam logic [5:0] ALU_NE   = 6'b001101;

    localparam logic [1:0] WB_EX  = 2'd0;
    localparam logic [1:0] WB_LSU = 2'd1;
    localparam logic [1:0] WB_MDU = 2'd2;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic             dec_valid;
    logic [31:0]      dec_instr, dec_pc;
    logic [1:0]       op_a_q, wb_q;
    logic [2:0]       op_b_q, mdu_op_q, mem_size_q;
    logic [5:0]       alu_q;
    logic             mdu_req_q, mem_req_q, mem_we_q, gpr_we_q;
    logic             branch_q, jal_q, jalr_q, illegal_q;
    logic [ILL_CNT_W-1:0] ill_cnt;

    logic        instr_ready, push, pop;
    logic [31:0] head_instr, head_pc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [1:0] d_op_a, d_wb;
    logic [2:0] d_op_b, d_mdu_op, d_mem_size;
    logic [5:0] d_alu;
    logic       d_mdu_req, d_mem_req, d_mem_we, d_gpr_we;
    logic       d_branch, d_jal, d_jalr, d_ill;

    assign instr_ready = (count < DEPTH_CNT);
    assign push        = bus.instr_valid_i && instr_ready && !bus.flush_i;
    assign pop         = (count != '0) && (!dec_valid || bus.dec_ready_i);
    assign head_instr  = mem_instr[rd_ptr];
    assign head_pc     = mem_pc[rd_ptr];
    assign funct3      = head_instr[14:12];
    assign funct7      = head_instr[31:25];

    always_comb begin
        d_op_a = OP_A_RS1;  d_op_b = OP_B_RS2;  d_alu = '0;
        d_mdu_req = 1'b0;   d_mdu_op = '0;
        d_mem_req = 1'b0;   d_mem_we = 1'b0;    d_mem_size = '0;
        d_gpr_we = 1'b0;    d_wb = WB_EX;
        d_branch = 1'b0;    d_jal = 1'b0;       d_jalr = 1'b0;
        d_ill = 1'b0;
        if (head_instr[1:0] != 2'b11) begin
            d_ill = 1'b1;
        end else begin
            case (head_instr[6:2])
                OPC_LOAD: begin
                    d_ill      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                    d_op_b     = OP_B_IMM_I;
                    d_alu      = ALU_ADD;
                    d_mem_req  = 1'b1;
                    d_mem_size = funct3;
                    d_gpr_we   = 1'b1;
                    d_wb       = WB_LSU;
                end
                OPC_STORE: begin
                    d_ill      = funct3[2] || (funct3[1:0] == 2'b11);
                    d_op_b     = OP_B_IMM_S;
                    d_alu      = ALU_ADD;
                    d_mem_req  = 1'b1;
                    d_mem_we   = 1'b1;
                    d_mem_size = funct3;
                end
                OPC_OPIMM: begin
                    d_op_b   = OP_B_IMM_I;
                    d_gpr_we = 1'b1;
                    case (funct3)
                        3'b000: d_alu = ALU_ADD;
                        3'b010: d_alu = ALU_SLTS;
                        3'b011: d_alu = ALU_SLTU;
                        3'b100: d_alu = ALU_XOR;
                        3'b110: d_alu = ALU_OR;
                        3'b111: d_alu = ALU_AND;
                        3'b001: begin
                            d_alu = ALU_SLL;
                            d_ill = (funct7 != 7'h00);
                        end
                        default: begin
                            d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                            d_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
                        end
                    endcase
                end
                OPC_OP: begin
                    d_gpr_we = 1'b1;
                    if (funct7 == 7'h01) begin
                        // MUL/DIV goes to the MDU; the ALU just sees a benign ADD
                        d_ill     = (ENABLE_M == 0);
                        d_alu     = ALU_ADD;
                        d_mdu_req = 1'b1;
                        d_mdu_op  = funct3;
                        d_wb      = WB_MDU;
                    end else if ((funct7 == 7'h00) || (funct7 == 7'h20)) begin
                        d_ill = funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101);
                        case (funct3)
                            3'b000:  d_alu = funct7[5] ? ALU_SUB : ALU_ADD;
                            3'b001:  d_alu = ALU_SLL;
                            3'b010:  d_alu = ALU_SLTS;
                            3'b011:  d_alu = ALU_SLTU;
                            3'b100:  d_alu = ALU_XOR;
                            3'b101:  d_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                            3'b110:  d_alu = ALU_OR;
                            default: d_alu = ALU_AND;
                        endcase
                    end else begin
                        d_ill = 1'b1;
                    end
                end
                OPC_LUI: begin
                    d_op_a = OP_A_ZERO;  d_op_b = OP_B_IMM_U;
                    d_alu  = ALU_ADD;    d_gpr_we = 1'b1;
                end
                OPC_AUIPC: begin
                    d_op_a = OP_A_CURR_PC;  d_op_b = OP_B_IMM_U;
                    d_alu  = ALU_ADD;       d_gpr_we = 1'b1;
                end
                OPC_JAL: begin
                    d_op_a = OP_A_CURR_PC;  d_op_b = OP_B_INCR;
                    d_alu  = ALU_ADD;       d_gpr_we = 1'b1;  d_jal = 1'b1;
                end
                OPC_JALR: begin
                    d_op_a = OP_A_CURR_PC;  d_op_b = OP_B_INCR;
                    d_alu  = ALU_ADD;       d_gpr_we = 1'b1;  d_jalr = 1'b1;
                    d_ill  = (funct3 != 3'b000);
                end
                OPC_BRANCH: begin
                    d_branch = 1'b1;
                    case (funct3)
                        3'b000:  d_alu = ALU_EQ;
                        3'b001:  d_alu = ALU_NE;
                        3'b100:  d_alu = ALU_LTS;
                        3'b101:  d_alu = ALU_GES;
                        3'b110:  d_alu = ALU_LTU;
                        3'b111:  d_alu = ALU_GEU;
                        default: d_ill = 1'b1;
                    endcase
                end
                OPC_MISC:   d_ill = (funct3 != 3'b000);
                OPC_SYSTEM: d_ill = (head_instr != 32'h0000_0073) && (head_instr != 32'h0010_0073);
                default:    d_ill = 1'b1;
            endcase
        end
        if (d_ill) begin
            d_op_a = '0;  d_op_b = '0;  d_alu = '0;
            d_mdu_req = 1'b0;  d_mdu_op = '0;
            d_mem_req = 1'b0;  d_mem_we = 1'b0;  d_mem_size = '0;
            d_gpr_we = 1'b0;   d_wb = '0;
            d_branch = 1'b0;   d_jal = 1'b0;     d_jalr = 1'b0;
        end
    end

    // Storage carries no reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.instr_i;
            mem_pc[wr_ptr]    <= bus.instr_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;  rd_ptr <= '0;  count <= '0;
            dec_valid <= 1'b0;  dec_instr <= '0;  dec_pc <= '0;
            op_a_q <= '0;  op_b_q <= '0;  alu_q <= '0;
            mdu_req_q <= 1'b0;  mdu_op_q <= '0;
            mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_size_q <= '0;
            gpr_we_q <= 1'b0;   wb_q <= '0;
            branch_q <= 1'b0;   jal_q <= 1'b0;  jalr_q <= 1'b0;
            illegal_q <= 1'b0;  ill_cnt <= '0;
        end else begin
            if (dec_valid && bus.dec_ready_i && illegal_q && (ill_cnt != '1))
                ill_cnt <= ill_cnt + 1'b1;
            if (bus.flush_i) begin
                wr_ptr <= '0;  rd_ptr <= '0;  count <= '0;
                dec_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
                if (pop) begin
                    dec_valid <= 1'b1;  dec_instr <= head_instr;  dec_pc <= head_pc;
                    op_a_q <= d_op_a;   op_b_q <= d_op_b;  alu_q <= d_alu;
                    mdu_req_q <= d_mdu_req;  mdu_op_q <= d_mdu_op;
                    mem_req_q <= d_mem_req;  mem_we_q <= d_mem_we;  mem_size_q <= d_mem_size;
                    gpr_we_q <= d_gpr_we;    wb_q <= d_wb;
                    branch_q <= d_branch;    jal_q <= d_jal;  jalr_q <= d_jalr;
                    illegal_q <= d_ill;
                end else if (bus.dec_ready_i) begin
                    dec_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.instr_ready_o   = instr_ready;
    assign bus.dec_valid_o     = dec_valid;
    assign bus.dec_instr_o     = dec_instr;
    assign bus.dec_pc_o        = dec_pc;
    assign bus.ex_op_a_sel_o   = op_a_q;
    assign bus.ex_op_b_sel_o   = op_b_q;
    assign bus.alu_op_o        = alu_q;
    assign bus.mdu_req_o       = mdu_req_q;
    assign bus.mdu_op_o        = mdu_op_q;
    assign bus.mem_req_o       = mem_req_q;
    assign bus.mem_we_o        = mem_we_q;
    assign bus.mem_size_o      = mem_size_q;
    assign bus.gpr_we_a_o      = gpr_we_q;
    assign bus.wb_src_sel_o    = wb_q;
    assign bus.branch_o        = branch_q;
    assign bus.jal_o           = jal_q;
    assign bus.jalr_o          = jalr_q;
    assign bus.illegal_instr_o = illegal_q;
    assign bus.ill_cnt_o       = ill_cnt;
endmodule
`default_nettype wire

// File: tb/tb_miriscv_decode_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_miriscv_decode_queue: scoreboard bench, M and no-M variants. Rev 1.0
// ------------------------------------------------------------------
module tb_miriscv_decode_queue;
    localparam int DEPTH = 4;

    localparam logic [1:0] A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
    localparam logic [2:0] B_RS2 = 3'd0, B_IMM_I = 3'd1, B_IMM_U = 3'd2, B_IMM_S = 3'd3, B_INCR = 3'd4;
    localparam logic [5:0] ALU_ADD = 6'b011000, ALU_SUB = 6'b011001, ALU_SRA = 6'b100100, ALU_EQ = 6'b001100;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  op_a;
        logic [2:0]  op_b;
        logic [5:0]  alu;
        logic        mdu_req;
        logic [2:0]  mdu_op;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        gpr_we;
        logic [1:0]  wb;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic        valid;
        logic        rdy;
        bundle_t     b;
        logic [31:0] cnt;
    } obs_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, ivalid = 1'b0, dready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    int          checks = 0, errors = 0, n_acc = 0;
    bundle_t     expq [2][$];
    int          exp_cnt [2];
    int          cnt_max [2];
    logic        rst_q = 1'b0, fl_q = 1'b0;
    obs_t        obs_a, obs_b;

    always #5 clk = ~clk;

    miriscv_decode_queue_if #(.ILL_CNT_W(2))  bus_a ();
    miriscv_decode_queue_if #(.ILL_CNT_W(16)) bus_b ();

    assign bus_a.flush_i = flush;   assign bus_b.flush_i = flush;
    assign bus_a.instr_valid_i = ivalid;  assign bus_b.instr_valid_i = ivalid;
    assign bus_a.instr_i = instr;   assign bus_b.instr_i = instr;
    assign bus_a.instr_pc_i = pc;   assign bus_b.instr_pc_i = pc;
    assign bus_a.dec_ready_i = dready;  assign bus_b.dec_ready_i = dready;

    miriscv_decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1), .ILL_CNT_W(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a));
    miriscv_decode_queue #(.DEPTH(DEPTH), .ENABLE_M(0), .ILL_CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b));

    always_comb begin
        obs_a = '0;
        obs_a.valid = bus_a.dec_valid_o;   obs_a.rdy = bus_a.instr_ready_o;
        obs_a.b.instr = bus_a.dec_instr_o; obs_a.b.pc = bus_a.dec_pc_o;
        obs_a.b.op_a = bus_a.ex_op_a_sel_o; obs_a.b.op_b = bus_a.ex_op_b_sel_o;
        obs_a.b.alu = bus_a.alu_op_o;      obs_a.b.mdu_req = bus_a.mdu_req_o;
        obs_a.b.mdu_op = bus_a.mdu_op_o;   obs_a.b.mem_req = bus_a.mem_req_o;
        obs_a.b.mem_we = bus_a.mem_we_o;   obs_a.b.mem_size = bus_a.mem_size_o;
        obs_a.b.gpr_we = bus_a.gpr_we_a_o; obs_a.b.wb = bus_a.wb_src_sel_o;
        obs_a.b.branch = bus_a.branch_o;   obs_a.b.jal = bus_a.jal_o;
        obs_a.b.jalr = bus_a.jalr_o;       obs_a.b.illegal = bus_a.illegal_instr_o;
        obs_a.cnt = 32'(bus_a.ill_cnt_o);
    end

    always_comb begin
        obs_b = '0;
        obs_b.valid = bus_b.dec_valid_o;   obs_b.rdy = bus_b.instr_ready_o;
        obs_b.b.instr = bus_b.dec_instr_o; obs_b.b.pc = bus_b.dec_pc_o;
        obs_b.b.op_a = bus_b.ex_op_a_sel_o; obs_b.b.op_b = bus_b.ex_op_b_sel_o;
        obs_b.b.alu = bus_b.alu_op_o;      obs_b.b.mdu_req = bus_b.mdu_req_o;
        obs_b.b.mdu_op = bus_b.mdu_op_o;   obs_b.b.mem_req = bus_b.mem_req_o;
        obs_b.b.mem_we = bus_b.mem_we_o;   obs_b.b.mem_size = bus_b.mem_size_o;
        obs_b.b.gpr_we = bus_b.gpr_we_a_o; obs_b.b.wb = bus_b.wb_src_sel_o;
        obs_b.b.branch = bus_b.branch_o;   obs_b.b.jal = bus_b.jal_o;
        obs_b.b.jalr = bus_b.jalr_o;       obs_b.b.illegal = bus_b.illegal_instr_o;
        obs_b.cnt = 32'(bus_b.ill_cnt_o);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Hand-decoded expectations for every word the bench issues.
    function automatic bundle_t exp_of(input logic [31:0] ins, input logic [31:0] p, input bit m_en);
        bundle_t e;
        e = '0;  e.instr = ins;  e.pc = p;
        if (ins[19:0] == 20'h00093) begin
            e.op_b = B_IMM_I; e.alu = ALU_ADD; e.gpr_we = 1'b1;
        end else begin
            case (ins)
                32'h0000A103: begin
                    e.op_b = B_IMM_I; e.alu = ALU_ADD; e.mem_req = 1'b1;
                    e.mem_size = 3'd2; e.gpr_we = 1'b1; e.wb = 2'd1;
                end
                32'h0020A023: begin
                    e.op_b = B_IMM_S; e.alu = ALU_ADD; e.mem_req = 1'b1;
                    e.mem_we = 1'b1; e.mem_size = 3'd2;
                end
                32'h022081B3: begin
                    if (m_en) begin
                        e.alu = ALU_ADD; e.mdu_req = 1'b1; e.mdu_op = 3'd0;
                        e.gpr_we = 1'b1; e.wb = 2'd2;
                    end else begin
                        e.illegal = 1'b1;
                    end
                end
                32'h40208133: begin e.op_b = B_RS2; e.alu = ALU_SUB; e.gpr_we = 1'b1; end
                32'h00208463: begin e.alu = ALU_EQ; e.branch = 1'b1; end
                32'h123450B7: begin e.op_a = A_ZERO; e.op_b = B_IMM_U; e.alu = ALU_ADD; e.gpr_we = 1'b1; end
                32'h00000097: begin e.op_a = A_PC; e.op_b = B_IMM_U; e.alu = ALU_ADD; e.gpr_we = 1'b1; end
                32'h008000EF: begin e.op_a = A_PC; e.op_b = B_INCR; e.alu = ALU_ADD; e.gpr_we = 1'b1; e.jal = 1'b1; end
                32'h000080E7: begin e.op_a = A_PC; e.op_b = B_INCR; e.alu = ALU_ADD; e.gpr_we = 1'b1; e.jalr = 1'b1; end
                32'h00000073, 32'h0000000F: ;
                32'h4020D093: begin e.op_b = B_IMM_I; e.alu = ALU_SRA; e.gpr_we = 1'b1; end
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic mon_step(input int d, input obs_t o);
        string   s;
        bundle_t e;
        s = (d == 0) ? "a" : "b";
        if (rst_q) begin
            expq[d].delete();
            exp_cnt[d] = 0;
            chk({"reset_outputs_", s}, 128'({o.valid, o.b, o.cnt}), 128'(0));
            chk({"reset_ready_", s}, 128'(o.rdy), 128'(1));
        end else begin
            if (fl_q) begin
                expq[d].delete();
                chk({"flush_valid_", s}, 128'(o.valid), 128'(0));
                chk({"flush_ready_", s}, 128'(o.rdy), 128'(1));
            end
            chk({"ill_cnt_", s}, 128'(o.cnt), 128'(exp_cnt[d]));
            if (o.valid && dready) begin
                if (expq[d].size() == 0) begin
                    chk({"unexpected_bundle_", s}, 128'(o.b), 128'(0));
                    if (o.b == '0) begin
                        errors++;
                        $display("FAIL unexpected_bundle_%s: got a zero bundle, expected none", s);
                    end
                end else begin
                    e = expq[d].pop_front();
                    chk({"bundle_", s}, 128'(o.b), 128'(e));
                    if (e.illegal)
                        exp_cnt[d] = (exp_cnt[d] == cnt_max[d]) ? cnt_max[d] : exp_cnt[d] + 1;
                end
            end
        end
    endtask

    initial begin
        cnt_max[0] = 3;  cnt_max[1] = 65535;
        exp_cnt[0] = 0;  exp_cnt[1] = 0;
        forever begin
            @(posedge clk);
            rst_q = rst;
            fl_q  = flush;
            @(negedge clk);
            mon_step(0, obs_a);
            mon_step(1, obs_b);
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic fl, input logic rdy, input logic r, output logic acc);
        ivalid = v; instr = ins; pc = p; flush = fl; dready = rdy; rst = r;
        @(negedge clk);
        acc = v && bus_a.instr_ready_o && !fl && !r;
        @(posedge clk);
        if (acc) begin
            expq[0].push_back(exp_of(ins, p, 1'b1));
            expq[1].push_back(exp_of(ins, p, 1'b0));
            n_acc++;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, a);
    endtask

    logic [31:0] vec [12];
    logic [31:0] w;
    logic        a;
    int          idx, guard;

    initial begin
        vec[0] = 32'h40208133; vec[1] = 32'h00208463; vec[2]  = 32'h123450B7; vec[3]  = 32'h00000097;
        vec[4] = 32'h008000EF; vec[5] = 32'h000080E7; vec[6]  = 32'h00000073; vec[7]  = 32'h0000000F;
        vec[8] = 32'h4020D093; vec[9] = 32'h40209093; vec[10] = 32'h00003003; vec[11] = 32'h4020F133;

        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, a);

        // addi: loaded one edge after acceptance
        step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b1, 1'b0, a);
        ivalid = 1'b0;
        @(negedge clk); chk("latency_edge_n", 128'(bus_a.dec_valid_o), 128'(0));
        @(posedge clk); #1;
        @(negedge clk); chk("latency_edge_n1", 128'(bus_a.dec_valid_o), 128'(1));
        @(posedge clk); #1;

        step(1'b1, 32'h0000A103, 32'h4, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 32'h0020A023, 32'h8, 1'b0, 1'b1, 1'b0, a);
        ivalid = 1'b0;
        @(negedge clk); chk("load_issue", 128'(bus_a.dec_instr_o), 128'(32'h0000A103));
        @(posedge clk); #1;
        @(negedge clk); chk("store_next_cycle", 128'(bus_a.dec_instr_o), 128'(32'h0020A023));
        @(posedge clk); #1;

        step(1'b1, 32'h022081B3, 32'hC, 1'b0, 1'b1, 1'b0, a);
        idle(3, 1'b1);

        for (int i = 0; i < 12; i++)
            step(1'b1, vec[i], 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0, a);
        idle(4, 1'b1);

        // Backpressure: FIFO plus output register absorb DEPTH+1 words
        n_acc = 0;  idx = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            w = 32'h00000093 | (32'(idx + 1) << 20);
            step(1'b1, w, 32'h200 + 32'(4 * idx), 1'b0, 1'b0, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_accepted", 128'(n_acc), 128'(DEPTH + 1));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_ready_low", 128'(bus_a.instr_ready_o), 128'(0));
            chk("bp_hold_valid", 128'(bus_a.dec_valid_o), 128'(1));
            chk("bp_hold_instr", 128'({bus_a.dec_instr_o, bus_a.dec_pc_o}), 128'({32'h00100093, 32'h200}));
            @(posedge clk); #1;
        end
        guard = 0;
        while (idx < DEPTH + 2 && guard < 20) begin
            w = 32'h00000093 | (32'(idx + 1) << 20);
            step(1'b1, w, 32'h200 + 32'(4 * idx), 1'b0, 1'b1, 1'b0, a);
            if (a) idx++;
            guard++;
        end
        chk("bp_release_all_accepted", 128'(idx), 128'(DEPTH + 2));
        idle(8, 1'b1);

        // Flush with a concurrent push; the offered word must vanish
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h01000093 + (32'(i) << 20), 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h7FF00093, 32'h3FC, 1'b1, 1'b0, 1'b0, a);
        idle(4, 1'b1);
        step(1'b1, 32'h02A00093, 32'h400, 1'b0, 1'b1, 1'b0, a);
        idle(4, 1'b1);

        // Counter saturation on the 2-bit instance
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, a);
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0, 32'h500 + 32'(4 * i), 1'b0, 1'b1, 1'b0, a);
        idle(4, 1'b1);
        @(negedge clk);
        chk("sat_final_a", 128'(bus_a.ill_cnt_o), 128'(3));
        chk("sat_final_b", 128'(bus_b.ill_cnt_o), 128'(5));
        @(posedge clk); #1;

        // Reset in the middle of traffic
        step(1'b1, 32'h00300093, 32'h600, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h00400093, 32'h604, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h00500093, 32'h608, 1'b0, 1'b0, 1'b1, a);
        idle(2, 1'b1);
        step(1'b1, 32'h0000A103, 32'h700, 1'b0, 1'b1, 1'b0, a);

        guard = 0;
        while ((expq[0].size() != 0 || expq[1].size() != 0) && guard < 30) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_a", 128'(expq[0].size()), 128'(0));
        chk("drain_b", 128'(expq[1].size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
